controlador_principal_param: RTL and testbench

- Parametrised successor of the pet main controller: same IDLE/COMENDO/DORMINDO/DANDO_AULA mode machine, driven by buttons b1/b2.
- Adds configurable attribute width, tick rate, increment and decay steps, a 2-FF button synchroniser with press detection, saturating arithmetic, time-based decay of idle attributes, and a terminal MORTO state.
- Sits between the board buttons and the display/sprite logic.

---
 rtl/tamagotchi_pkg.sv | 36 +++
 rtl/detector_botoes.sv | 28 ++
 rtl/controlador_principal_param.sv | 129 ++++++++++++
 tb/tb_controlador_principal_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared state codes, button event codes and saturating arithmetic for the
// parametrised pet controller.
package tamagotchi_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    COMENDO    = 3'b001,
    DORMINDO   = 3'b010,
    DANDO_AULA = 3'b011,
    MORTO      = 3'b100
  } estado_t;

  localparam logic [1:0] EV_B1    = 2'b01;
  localparam logic [1:0] EV_B2    = 2'b10;
  localparam logic [1:0] EV_AMBOS = 2'b11;

  localparam int MAX_W = 32;

  // Operands are at most MAX_W bits wide; the result is clamped to a w-bit range.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int               w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    lim = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
    s   = {1'b0, a} + {1'b0, b};
    if (s > lim) s = lim;
    return s[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b);
    return (b > a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/detector_botoes.sv
// Two-flop synchroniser for {b2,b1} plus rising-from-idle press detection.
module detector_botoes (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  output logic       ev_valid,
  output logic [1:0] ev_code
);

  logic [1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Only a press starting from all-released counts; 01->11 is not an event.
  assign ev_valid = (prev_q == 2'b00) && (sync2_q != 2'b00);
  assign ev_code  = sync2_q;

endmodule

// File: rtl/controlador_principal_param.sv
// Pet main controller: mode FSM, tick prescaler, decay counter and saturating
// attribute datapath, driven by synchronised button press events.
module controlador_principal_param
  import tamagotchi_pkg::*;
#(
  parameter int ATTR_W      = 8,
  parameter int TICK_CYCLES = 100,
  parameter int INC_STEP    = 10,
  parameter int DECAY_STEP  = 1,
  parameter int DECAY_TICKS = 3,
  parameter int INIT_VAL    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              b1,
  input  logic              b2,
  output logic [2:0]        estado,
  output logic [ATTR_W-1:0] fome,
  output logic [ATTR_W-1:0] sono,
  output logic [ATTR_W-1:0] felicidade,
  output logic              morto,
  output logic              tick
);

  localparam int                PW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int                DW    = $clog2(DECAY_TICKS + 1);
  localparam logic [ATTR_W-1:0] INIT  = ATTR_W'(INIT_VAL);
  localparam logic [MAX_W-1:0]  INC32 = MAX_W'(INC_STEP);
  localparam logic [MAX_W-1:0]  DEC32 = MAX_W'(DECAY_STEP);

  estado_t           st_q, st_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     dec_q, dec_d;
  logic [ATTR_W-1:0] fome_q, fome_d, sono_q, sono_d, fel_q, fel_d;
  logic              ev_valid, tick_w, dec_ev;
  logic [1:0]        ev_code;

  detector_botoes u_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      ({b2, b1}),
    .ev_valid (ev_valid),
    .ev_code  (ev_code)
  );

  always_comb begin
    st_d = st_q;
    // Death overrides any button event in the same cycle.
    if (st_q != MORTO && (fome_q == '0 || sono_q == '0 || fel_q == '0)) begin
      st_d = MORTO;
    end else if (ev_valid) begin
      case (st_q)
        IDLE: begin
          if (ev_code == EV_B1)         st_d = COMENDO;
          else if (ev_code == EV_B2)    st_d = DORMINDO;
          else if (ev_code == EV_AMBOS) st_d = DANDO_AULA;
        end
        COMENDO:    if (ev_code == EV_B1)    st_d = IDLE;
        DORMINDO:   if (ev_code == EV_B2)    st_d = IDLE;
        DANDO_AULA: if (ev_code == EV_AMBOS) st_d = IDLE;
        MORTO:      if (ev_code == EV_AMBOS) st_d = IDLE;
        default:    st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_w  = (st_q != MORTO) && (presc_q == PW'(TICK_CYCLES - 1));
    dec_ev  = tick_w && (dec_q == DW'(DECAY_TICKS - 1));
    presc_d = presc_q;
    dec_d   = dec_q;
    if (st_d != st_q) begin
      presc_d = '0;
      dec_d   = '0;
    end else if (tick_w) begin
      presc_d = '0;
      dec_d   = dec_ev ? '0 : dec_q + 1'b1;
    end else if (st_q != MORTO) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Updates use the pre-transition state; MORTO freezes until revived.
  always_comb begin
    fome_d = fome_q;
    sono_d = sono_q;
    fel_d  = fel_q;
    if (st_q == MORTO) begin
      if (st_d == IDLE) begin
        fome_d = INIT;
        sono_d = INIT;
        fel_d  = INIT;
      end
    end else if (tick_w) begin
      if (st_q == COMENDO)    fome_d = ATTR_W'(sat_add(MAX_W'(fome_q), INC32, ATTR_W));
      else if (dec_ev)        fome_d = ATTR_W'(sat_sub(MAX_W'(fome_q), DEC32));
      if (st_q == DORMINDO)   sono_d = ATTR_W'(sat_add(MAX_W'(sono_q), INC32, ATTR_W));
      else if (dec_ev)        sono_d = ATTR_W'(sat_sub(MAX_W'(sono_q), DEC32));
      if (st_q == DANDO_AULA) fel_d  = ATTR_W'(sat_add(MAX_W'(fel_q), INC32, ATTR_W));
      else if (dec_ev)        fel_d  = ATTR_W'(sat_sub(MAX_W'(fel_q), DEC32));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      presc_q <= '0;
      dec_q   <= '0;
      fome_q  <= INIT;
      sono_q  <= INIT;
      fel_q   <= INIT;
    end else begin
      st_q    <= st_d;
      presc_q <= presc_d;
      dec_q   <= dec_d;
      fome_q  <= fome_d;
      sono_q  <= sono_d;
      fel_q   <= fel_d;
    end
  end

  assign estado     = st_q;
  assign fome       = fome_q;
  assign sono       = sono_q;
  assign felicidade = fel_q;
  assign morto      = (st_q == MORTO);
  assign tick       = tick_w;

endmodule

// File: tb/tb_controlador_principal_param.sv
// Scoreboard bench: three instances (default, INIT_VAL=250, INIT_VAL=2 with
// DECAY_TICKS=1) share clock and reset; expectations queue up as stimulus goes in.
module tb_controlador_principal_param;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] f;
    logic [7:0] s;
    logic [7:0] h;
    logic       m;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn0, btn1, btn2;
  logic [2:0] est0, est1, est2;
  logic [7:0] f0, s0, h0, f1, s1, h1, f2, s2, h2;
  logic       m0, m1, m2, t0, t1, t2;

  exp_t q[$];
  exp_t e, a;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   q_int[$];

  always #5 clk = ~clk;

  controlador_principal_param dut0 (
    .clk(clk), .rst_n(rst_n), .b1(btn0[0]), .b2(btn0[1]), .estado(est0),
    .fome(f0), .sono(s0), .felicidade(h0), .morto(m0), .tick(t0));

  controlador_principal_param #(.INIT_VAL(250)) dut1 (
    .clk(clk), .rst_n(rst_n), .b1(btn1[0]), .b2(btn1[1]), .estado(est1),
    .fome(f1), .sono(s1), .felicidade(h1), .morto(m1), .tick(t1));

  controlador_principal_param #(.INIT_VAL(2), .DECAY_TICKS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .b1(btn2[0]), .b2(btn2[1]), .estado(est2),
    .fome(f2), .sono(s2), .felicidade(h2), .morto(m2), .tick(t2));

  function automatic exp_t mk(input logic [2:0] st, input int f, input int s,
                              input int h, input logic m);
    exp_t r;
    r.st = st; r.f = 8'(f); r.s = 8'(s); r.h = 8'(h); r.m = m;
    return r;
  endfunction

  function automatic exp_t snap(input int d);
    exp_t r;
    case (d)
      0:       r = {est0, f0, s0, h0, m0};
      1:       r = {est1, f1, s1, h1, m1};
      default: r = {est2, f2, s2, h2, m2};
    endcase
    return r;
  endfunction

  task automatic set_btn(input int d, input logic [1:0] c);
    case (d)
      0:       btn0 = c;
      1:       btn1 = c;
      default: btn2 = c;
    endcase
  endtask

  // Two-cycle press; returns at the negedge after the edge where estado reacts.
  task automatic press(input int d, input logic [1:0] c);
    @(negedge clk); set_btn(d, c);
    @(posedge clk); @(posedge clk);
    @(negedge clk); set_btn(d, 2'b00);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn0 = 2'b00; btn1 = 2'b00; btn2 = 2'b00;
    q.push_back(mk(3'b000, 128, 128, 128, 1'b0));
    q.push_back(mk(3'b000, 250, 250, 250, 1'b0));
    q.push_back(mk(3'b000, 2, 2, 2, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk); btn0 = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk); btn0 = 2'b00;
    for (int d = 0; d < 3; d++) begin
      a = snap(d); e = q.pop_front(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL reset_state dut%0d: got %h want %h", d, a, e); end
    end
    n_chk++;
    if ({t0, t1, t2} !== 3'b000) begin n_fail++; $display("FAIL reset_tick: got %b want 000", {t0, t1, t2}); end
    rst_n = 1'b1;
  endtask

  task automatic test_eating();
    q.push_back(mk(3'b001, 128, 128, 128, 1'b0));
    press(0, 2'b01);
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL eat_enter: got %h want %h", a, e); end
    q.push_back(mk(3'b001, 158, 127, 127, 1'b0));
    repeat (300) @(posedge clk);
    @(negedge clk);
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL eat_3ticks: got %h want %h", a, e); end
    q.push_back(mk(3'b000, 158, 127, 127, 1'b0));
    press(0, 2'b01);
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL eat_leave: got %h want %h", a, e); end
  endtask

  task automatic test_wrong_buttons();
    logic [1:0] codes [5];
    logic [2:0] want  [5];
    codes = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    want  = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b000};
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(want[i], 158, 127, 127, 1'b0));
      press(0, codes[i]);
      a = snap(0); e = q.pop_front(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL wrong_btn step%0d: got %h want %h", i, a, e); end
    end
    // Held b1 leaves COMENDO; adding b2 on top must not produce an event.
    q.push_back(mk(3'b000, 158, 127, 127, 1'b0));
    @(negedge clk); btn0 = 2'b01;
    repeat (4) @(posedge clk);
    @(negedge clk); btn0 = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL held_01_to_11: got %h want %h", a, e); end
    btn0 = 2'b00;
    repeat (4) @(posedge clk);
    q.push_back(mk(3'b011, 158, 127, 127, 1'b0));
    press(0, 2'b11);
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL both_press: got %h want %h", a, e); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (57) @(posedge clk);
    @(negedge clk);
    q.push_back(mk(3'b000, 128, 128, 128, 1'b0));
    #1 rst_n = 1'b0;
    #1;
    a = snap(0); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL reset_mid_state: got %h want %h", a, e); end
    @(negedge clk); rst_n = 1'b1;
    q_int.push_back(99);
    n = 0;
    while (n < 300) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (t0) break;
    end
    n_chk++;
    if (n !== q_int.pop_front()) begin n_fail++; $display("FAIL reset_mid_first_tick: got %0d edges want 99", n); end
  endtask

  task automatic test_saturation();
    do_reset();
    q.push_back(mk(3'b001, 250, 250, 250, 1'b0));
    press(1, 2'b01);
    a = snap(1); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL sat_enter: got %h want %h", a, e); end
    q.push_back(mk(3'b001, 255, 250, 250, 1'b0));
    repeat (200) @(posedge clk);
    @(negedge clk);
    a = snap(1); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL sat_2ticks: got %h want %h", a, e); end
    q.push_back(mk(3'b001, 255, 249, 249, 1'b0));
    repeat (100) @(posedge clk);
    @(negedge clk);
    a = snap(1); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL sat_hold: got %h want %h", a, e); end
  endtask

  task automatic test_death();
    int nt;
    do_reset();
    q.push_back(mk(3'b000, 0, 0, 0, 1'b0));
    repeat (200) @(posedge clk);
    @(negedge clk);
    a = snap(2); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL death_zero: got %h want %h", a, e); end
    q.push_back(mk(3'b100, 0, 0, 0, 1'b1));
    @(posedge clk); @(negedge clk);
    a = snap(2); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL death_morto: got %h want %h", a, e); end
    q.push_back(mk(3'b100, 0, 0, 0, 1'b1));
    q_int.push_back(0);
    press(2, 2'b01);
    nt = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); @(negedge clk);
      if (t2) nt++;
    end
    a = snap(2); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL death_b1_ignored: got %h want %h", a, e); end
    n_chk++;
    if (nt !== q_int.pop_front()) begin n_fail++; $display("FAIL death_no_tick: got %0d ticks want 0", nt); end
    q.push_back(mk(3'b000, 2, 2, 2, 1'b0));
    press(2, 2'b11);
    a = snap(2); e = q.pop_front(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL death_revive: got %h want %h", a, e); end
  endtask

  initial begin
    test_reset();
    test_eating();
    test_wrong_buttons();
    test_reset_mid();
    test_saturation();
    test_death();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule
